string_fifo_cmp_avalon: RTL and testbench

//  Avalon-MM slave string accelerator: two parametrised 32-bit word FIFOs (A, B) filled by the

---
 rtl/string_fifo_cmp_avalon.sv | 259 +++++++++++++++++++++++++
 tb/tb_string_fifo_cmp_avalon.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_fifo_cmp_avalon.sv
// string_fifo_cmp_avalon
// Avalon-MM string accelerator. Two word FIFOs (A, B) are filled by the CPU;
// a compare engine then pops both in lock-step and compares LEN bytes
// strcmp-style. It reports the leading-equal byte count and an equal flag.
// Bus reads have one cycle of latency. FIFO pops happen in the strobe cycle.
module string_fifo_cmp_avalon #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index of the first differing byte among the first n lanes, or n if all match.
  function automatic logic [2:0] first_diff(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [2:0]  n);
    logic [2:0] idx;
    idx = n;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) < n) && (a[8*i +: 8] != b[8*i +: 8])) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // FIFO storage and pointers; index 0 is FIFO A, index 1 is FIFO B.
  logic [31:0]             mem_q [2][DEPTH];
  logic [1:0][AW-1:0]      wptr_q, wptr_d;
  logic [1:0][AW-1:0]      rptr_q, rptr_d;
  logic [1:0][CW-1:0]      cnt_q, cnt_d;

  // Engine and status state.
  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [LEN_W-1:0]        match_q, match_d;
  logic                    equal_q, equal_d;
  logic                    done_q, done_d;
  logic                    irq_en_q, irq_en_d;
  logic [1:0]              ovf_q, ovf_d;
  logic [1:0]              udf_q, udf_d;
  logic [31:0]             readdata_q, readdata_d;
  logic                    irq_q, irq_d;

  // Decoded bus and datapath signals.
  logic                    wr_s, rd_s, ctrl_wr_s, busy_s;
  logic                    go_s, clr_err_s, ack_s, abort_s, eng_step_s;
  logic [LEN_W-1:0]        len_s;
  logic [1:0]              clr_s, empty_s, full_s;
  logic [1:0]              bus_req_s, bus_pop_s, push_req_s, pop_s, push_s;
  logic [1:0]              ovf_set_s, udf_set_s;
  logic [1:0][31:0]        head_s;
  logic [2:0]              n_s, k_s;
  logic                    unused_wdata_s;

  assign unused_wdata_s = ^writedata[15:6];

  // Bus decode, FIFO occupancy and push/pop qualification.
  always_comb begin
    wr_s       = chipselect & write;
    rd_s       = chipselect & read;
    ctrl_wr_s  = wr_s && (address == 3'd2);
    busy_s     = (state_q == ST_RUN);
    go_s       = ctrl_wr_s & writedata[0];
    clr_s      = {ctrl_wr_s & writedata[2], ctrl_wr_s & writedata[1]};
    clr_err_s  = ctrl_wr_s & writedata[3];
    ack_s      = ctrl_wr_s & writedata[5];
    len_s      = writedata[16 +: LEN_W];
    abort_s    = busy_s && (clr_s != 2'b00);
    for (int f = 0; f < 2; f++) begin
      empty_s[f] = (cnt_q[f] == CW'(0));
      full_s[f]  = (cnt_q[f] == CW'(DEPTH));
      head_s[f]  = mem_q[f][rptr_q[f]];
    end
    eng_step_s = busy_s && !empty_s[0] && !empty_s[1] && !abort_s;
    n_s        = (rem_q >= LEN_W'(4)) ? 3'd4 : rem_q[2:0];
    k_s        = first_diff(head_s[0], head_s[1], n_s);
    for (int f = 0; f < 2; f++) begin
      bus_req_s[f]  = rd_s && (address == 3'(f)) && !busy_s;
      bus_pop_s[f]  = bus_req_s[f] && !empty_s[f];
      udf_set_s[f]  = bus_req_s[f] && empty_s[f] && !clr_s[f];
      pop_s[f]      = (bus_pop_s[f] | eng_step_s) & ~clr_s[f];
      push_req_s[f] = wr_s && (address == 3'(f)) && !clr_s[f];
      push_s[f]     = push_req_s[f] && (!full_s[f] || pop_s[f]);
      ovf_set_s[f]  = push_req_s[f] && full_s[f] && !pop_s[f];
    end
  end

  // FIFO pointer/count next state; a flush overrides any push or pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    for (int f = 0; f < 2; f++) begin
      if (clr_s[f]) begin
        wptr_d[f] = AW'(0);
        rptr_d[f] = AW'(0);
        cnt_d[f]  = CW'(0);
      end else begin
        wptr_d[f] = wptr_q[f] + AW'(push_s[f]);
        rptr_d[f] = rptr_q[f] + AW'(pop_s[f]);
        cnt_d[f]  = cnt_q[f] + CW'(push_s[f]) - CW'(pop_s[f]);
      end
    end
  end

  // Compare engine FSM: start on go, step one word pair per cycle, report done.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    match_d = match_q;
    equal_d = equal_q;
    if (clr_err_s || ack_s) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go_s) begin
          match_d = LEN_W'(0);
          rem_d   = len_s;
          if (len_s == LEN_W'(0)) begin
            equal_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            equal_d = 1'b0;
            done_d  = 1'b0;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (eng_step_s) begin
          if (k_s < n_s) begin
            match_d = match_q + LEN_W'(k_s);
            equal_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            match_d = match_q + LEN_W'(n_s);
            rem_d   = rem_q - LEN_W'(n_s);
            if (rem_q == LEN_W'(n_s)) begin
              equal_d = 1'b1;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error flags, irq enable, read data mux and interrupt level.
  always_comb begin
    ovf_d = (ovf_q & {~clr_err_s, ~clr_err_s}) | ovf_set_s;
    udf_d = (udf_q & {~clr_err_s, ~clr_err_s}) | udf_set_s;
    if (ctrl_wr_s) begin
      irq_en_d = writedata[4];
    end else begin
      irq_en_d = irq_en_q;
    end
    irq_d      = done_d & irq_en_d;
    readdata_d = readdata_q;
    if (rd_s) begin
      case (address)
        3'd0:    readdata_d = bus_pop_s[0] ? head_s[0] : 32'd0;
        3'd1:    readdata_d = bus_pop_s[1] ? head_s[1] : 32'd0;
        3'd2:    readdata_d = {20'd0, empty_s[1], full_s[1], empty_s[0], full_s[0],
                               irq_en_q, udf_q[1], udf_q[0], ovf_q[1], ovf_q[0],
                               equal_q, done_q, busy_s};
        3'd3: begin
          readdata_d     = 32'(match_q);
          readdata_d[16] = equal_q;
        end
        3'd4:    readdata_d = {16'(cnt_q[1]), 16'(cnt_q[0])};
        default: readdata_d = 32'd0;
      endcase
    end else begin
      readdata_d = readdata_q;
    end
  end

  // FIFO data array; written only on an accepted push.
  always_ff @(posedge clk) begin
    for (int f = 0; f < 2; f++) begin
      if (push_s[f]) begin
        mem_q[f][wptr_q[f]] <= writedata;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      rem_q      <= LEN_W'(0);
      match_q    <= LEN_W'(0);
      equal_q    <= 1'b0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 2'b00;
      udf_q      <= 2'b00;
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      rem_q      <= rem_d;
      match_q    <= match_d;
      equal_q    <= equal_d;
      done_q     <= done_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_string_fifo_cmp_avalon.sv
// Scoreboard bench for string_fifo_cmp_avalon: a byte-level string model
// predicts every read, a monitor compares each read response.
module tb_string_fifo_cmp_avalon;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic [2:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  always #5 clk = ~clk;

  string_fifo_cmp_avalon #(.DEPTH(DEPTH), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .write(write), .read(read), .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard
  logic [31:0] exp_q[$];
  string       name_q[$];

  // Reference model state
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] wa_q[$];
  logic [31:0] wb_q[$];
  bit          m_busy, m_done, m_equal, m_irq_en;
  bit [1:0]    m_ovf, m_udf;
  int          m_match, m_len;

  // Monitor: every read strobe yields one response one cycle later
  initial begin
    logic [31:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      if (chipselect && read && !reset) begin
        #1;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read got %h required none", readdata);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          checks++;
          if (readdata !== e) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, readdata, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] status_word();
    return {20'd0, qb.size() == 0, qb.size() == DEPTH, qa.size() == 0, qa.size() == DEPTH,
            m_irq_en, m_udf[1], m_udf[0], m_ovf[1], m_ovf[0], m_equal, m_done, m_busy};
  endfunction

  function automatic logic [31:0] result_word();
    return {15'd0, m_equal, 16'(m_match)};
  endfunction

  function automatic logic [31:0] level_word();
    return {16'(qb.size()), 16'(qa.size())};
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete(); wa_q.delete(); wb_q.delete();
    m_busy = 0; m_done = 0; m_equal = 0; m_irq_en = 0;
    m_ovf = 0; m_udf = 0; m_match = 0; m_len = 0;
  endtask

  // Engine model: consume word pairs while both queues hold data, judge bytes
  task automatic model_advance();
    int limit, mm;
    logic [31:0] a, b;
    while (m_busy && qa.size() > 0 && qb.size() > 0) begin
      wa_q.push_back(qa.pop_front());
      wb_q.push_back(qb.pop_front());
      limit = (4 * wa_q.size() < m_len) ? 4 * wa_q.size() : m_len;
      mm = -1;
      for (int k = 0; k < limit; k++) begin
        a = wa_q[k / 4];
        b = wb_q[k / 4];
        if (mm < 0 && a[8*(k%4) +: 8] != b[8*(k%4) +: 8]) mm = k;
      end
      if (mm >= 0) begin
        m_match = mm; m_equal = 0; m_done = 1; m_busy = 0;
      end else if (limit == m_len) begin
        m_match = m_len; m_equal = 1; m_done = 1; m_busy = 0;
      end else begin
        m_match = limit;
      end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic push(input int f, input logic [31:0] w);
    bus_write(3'(f), w);
    if (f == 0) begin
      if (qa.size() < DEPTH) qa.push_back(w); else m_ovf[0] = 1;
    end else begin
      if (qb.size() < DEPTH) qb.push_back(w); else m_ovf[1] = 1;
    end
  endtask

  task automatic pop(input int f);
    logic [31:0] e;
    e = 32'd0;
    if (!m_busy) begin
      if (f == 0) begin
        if (qa.size() == 0) m_udf[0] = 1; else e = qa.pop_front();
      end else begin
        if (qb.size() == 0) m_udf[1] = 1; else e = qb.pop_front();
      end
    end
    bus_read(3'(f), e, (f == 0) ? "pop_a" : "pop_b");
  endtask

  task automatic ctrl(input bit go, input bit ca, input bit cb, input bit ce,
                      input bit ie, input bit ack, input int len);
    bit was_busy;
    was_busy = m_busy;
    bus_write(3'd2, {16'(len), 10'd0, ack, ie, ce, cb, ca, go});
    m_irq_en = ie;
    if (ca) qa.delete();
    if (cb) qb.delete();
    if ((ca || cb) && was_busy) begin m_busy = 0; m_done = 0; end
    if (ce) begin m_ovf = 0; m_udf = 0; m_done = 0; end
    if (ack) m_done = 0;
    if (go && !was_busy) begin
      m_match = 0; m_equal = 0; m_done = 0; m_len = len;
      wa_q.delete(); wb_q.delete();
      if (len == 0) begin m_equal = 1; m_done = 1; end else m_busy = 1;
    end
    model_advance();
  endtask

  task automatic check_irq(input string nm);
    checks++;
    if (irq !== (m_done & m_irq_en)) begin
      errors++;
      $display("FAIL %s got irq=%b required %b", nm, irq, m_done & m_irq_en);
    end
  endtask

  task automatic check_rdata_zero(input string nm);
    checks++;
    if (readdata !== 32'd0) begin
      errors++;
      $display("FAIL %s got %h required 00000000", nm, readdata);
    end
  endtask

  task automatic read_all(input string tag);
    bus_read(3'd2, status_word(), {tag, "_ctrl"});
    bus_read(3'd3, result_word(), {tag, "_result"});
    bus_read(3'd4, level_word(), {tag, "_level"});
  endtask

  logic [31:0] ra[4];
  logic [31:0] rb[4];
  logic [31:0] tmp;

  initial begin
    int nw, len, p, n;
    bit ie;
    reset = 1'b1; chipselect = 1'b0; address = 3'd0; write = 1'b0; read = 1'b0;
    writedata = 32'd0;
    model_reset();
    settle(3);
    reset = 1'b0;
    check_rdata_zero("reset_readdata");
    check_irq("reset_irq");
    read_all("reset");

    // 1: mismatch at byte 4
    push(0, 32'h64636261); push(0, 32'h00006665);
    push(1, 32'h64636261); push(1, 32'h00006766);
    ctrl(1, 0, 0, 0, 0, 0, 6);
    settle(6);
    read_all("t1");

    // 2: equal strings, interrupt and acknowledge
    push(0, 32'h64636261); push(0, 32'h00006665);
    push(1, 32'h64636261); push(1, 32'h00006665);
    ctrl(1, 0, 0, 0, 1, 0, 6);
    settle(6);
    read_all("t2");
    check_irq("t2_irq_set");
    ctrl(0, 0, 0, 0, 1, 1, 0);
    check_irq("t2_irq_ack");

    // 3: stall on short data, resume when second words arrive
    push(0, 32'h64636261); push(1, 32'h64636261);
    ctrl(1, 0, 0, 0, 0, 0, 5);
    settle(4);
    bus_read(3'd2, status_word(), "t3_stalled");
    push(0, 32'h00006665); push(1, 32'h00006665);
    bus_read(3'd2, status_word(), "t3_one_after");
    model_advance();
    bus_read(3'd2, status_word(), "t3_two_after");
    bus_read(3'd3, result_word(), "t3_result");

    // 4: overflow, wrap-around order, underflow
    for (int i = 0; i < DEPTH + 1; i++) push(0, $urandom);
    bus_read(3'd2, status_word(), "t4_full");
    bus_read(3'd4, level_word(), "t4_level");
    for (int i = 0; i < DEPTH + 1; i++) pop(0);
    bus_read(3'd2, status_word(), "t4_empty");
    ctrl(0, 0, 0, 1, 0, 0, 0);

    // 5: engine pop and bus push on a full FIFO A in the same cycle
    for (int i = 0; i < DEPTH; i++) push(0, $urandom);
    ctrl(1, 0, 0, 0, 0, 0, 8);
    settle(2);
    push(1, qa[0]);
    model_advance();
    push(0, 32'hA5A5_0001);
    bus_read(3'd4, level_word(), "t5_level");
    bus_read(3'd2, status_word(), "t5_ctrl");
    push(1, qa[0] ^ 32'h0001_0000);
    model_advance();
    settle(3);
    bus_read(3'd3, result_word(), "t5_result");
    n = qa.size();
    for (int i = 0; i < n; i++) pop(0);
    bus_read(3'd4, level_word(), "t5_drained");

    // 6: zero length, abort by flush, reset mid-run
    ctrl(1, 0, 0, 0, 0, 0, 0);
    bus_read(3'd2, status_word(), "t6_len0");
    push(0, 32'h11223344); push(1, 32'h11223344);
    ctrl(1, 0, 0, 0, 0, 0, 8);
    settle(3);
    ctrl(0, 1, 0, 0, 0, 0, 0);
    read_all("t6_abort");
    push(0, 32'h55667788); push(1, 32'h55667788);
    ctrl(1, 0, 0, 0, 1, 0, 8);
    settle(3);
    reset = 1'b1;
    settle(2);
    reset = 1'b0;
    model_reset();
    check_rdata_zero("t6_reset_readdata");
    check_irq("t6_reset_irq");
    read_all("t6_reset");

    // Randomized strings
    for (int it = 0; it < 20; it++) begin
      nw = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) ra[i] = $urandom;
      rb = ra;
      if ($urandom_range(0, 1) == 1) begin
        p   = $urandom_range(0, 4 * nw - 1);
        tmp = rb[p / 4];
        tmp[8*(p%4) +: 8] = tmp[8*(p%4) +: 8] ^ 8'($urandom_range(1, 255));
        rb[p / 4] = tmp;
      end
      len = $urandom_range(0, 4 * nw);
      ie  = 1'($urandom_range(0, 1));
      for (int i = 0; i < nw; i++) push(0, ra[i]);
      for (int i = 0; i < nw; i++) push(1, rb[i]);
      ctrl(1, 0, 0, 0, ie, 0, len);
      settle(nw + 4);
      read_all("rand");
      check_irq("rand_irq");
      n = qa.size();
      for (int i = 0; i < n; i++) pop(0);
      n = qb.size();
      for (int i = 0; i < n; i++) pop(1);
      if (it % 5 == 0) begin
        pop(0);
        bus_read(3'd2, status_word(), "rand_udf");
      end
      ctrl(0, 0, 0, (it % 5 == 0), 0, 1, 0);
    end

    settle(3);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
